rtc_digit_buffer: RTL
=====================

Name: rtc_digit_buffer

Overview:
- Frame-synchronised digit register bank. Sits directly upstream of Clock_screen_top.
- Accepts BCD bytes (time, date, timer, control) from the RTC controller over a valid/ready write port and collects them in shadow registers.
- Copies a complete set to the display registers only at the start of vertical sync, so the character generator never shows a half-updated time or date within a frame.
- Drives the digit0_*/digit1_*, AM_PM and dia_semana inputs of the screen top.

Parameters:
- VSYNC_ACT, 0, level of vsync meaning "sync asserted" (0 = active-low pulse).
- NUM_REGS, 10, number of addressable byte registers. Fixed layout below; addresses at or above NUM_REGS are ignored.

Ports:
- clk  input  1  system clock, same clock as the VGA timing generator.
- reset  input  1  synchronous, active-low reset (reset=0 resets on the next clk edge).
- wr_en  input  1  write request valid.
- wr_addr  input  4  register address.
- wr_data  input  8  BCD byte: [7:4] tens, [3:0] units. For CTRL: [0]=AM_PM, [6:4]=dia_semana.
- wr_last  input  1  marks the final write of an update set; qualified by wr_en.
- wr_ready  output  1  write port can accept.
- vsync  input  1  vsync from timing generator.
- digit0_HH, digit1_HH, digit0_MM, digit1_MM, digit0_SS, digit1_SS  output  4 each  time units/tens.
- digit0_DAY, digit1_DAY, digit0_MES, digit1_MES, digit0_YEAR, digit1_YEAR  output  4 each  date units/tens.
- digit0_HH_T, digit1_HH_T, digit0_MM_T, digit1_MM_T, digit0_SS_T, digit1_SS_T  output  4 each  timer units/tens.
- AM_PM  output  1  AM/PM flag to display.
- dia_semana  output  3  day of week to display.
- pending  output  1  complete set waiting for frame commit.
- err  output  1  sticky: a write was rejected by the BCD check.

Behaviour:
- Address map: 0 SS, 1 MM, 2 HH, 3 DAY, 4 MES, 5 YEAR, 6 SS_T, 7 MM_T, 8 HH_T, 9 CTRL.
- Reset (reset=0 at a clk edge):
  - All shadow and display registers = 0.
  - AM_PM=0, dia_semana=0, pending=0, err=0.
  - Edge-detect register loaded with the deasserted level (!VSYNC_ACT).
  - wr_ready=0 during the reset cycle and 1 from the first cycle after reset is released.
  - A reset in the middle of a set discards the partial set.
- Write handshake:
  - wr_ready = !pending.
  - A write is accepted when wr_en=1 and wr_ready=1.
  - An accepted, valid write updates the shadow register on that clk edge.
  - Data is visible on the outputs only after commit, never directly.
  - Writes to address >= NUM_REGS are accepted and discarded; they do not set err.
- Update set:
  - An accepted write with wr_last=1 sets pending=1 on the same edge. This includes a write dropped by the address rule or the BCD check.
  - Addresses may be written in any order and any subset.
  - Registers not written keep their previous shadow value.
- Commit:
  - vs_start = (vsync==VSYNC_ACT) and (previous sampled vsync != VSYNC_ACT).
  - On the edge where vs_start=1 and pending=1: all display registers <= shadow registers, and pending <= 0.
  - Outputs change exactly 1 clk after the sampled vsync edge.
  - wr_ready returns to 1 in the following cycle.
- Simultaneous events:
  - wr_last is accepted in the same cycle as vs_start: pending was 0 in that cycle, so no commit happens. The set commits at the next frame.
  - vs_start with pending=0: no change.
  - vsync held asserted does not re-trigger; one commit per frame at most.
- Outputs are registered; no combinational path from wr_* to any digit output.
- err clears only on reset.

Optional Feature:
- Macro: RTC_BCD_CHECK_EN.
- Defined:
  - Data registers (addresses 0-8): the write is rejected if either nibble > 9.
  - CTRL (address 9): the write is rejected if dia_semana field == 7 or bits [3:1],[7] != 0.
  - A rejected write leaves the shadow register unchanged and sets err=1 on the acceptance edge.
  - The handshake still completes (the write is consumed), and wr_last is still honoured.
- Not defined:
  - All writes are stored unchecked.
  - err is tied to 0.

Test Plan:
- Reset, then write addr2=8'h12, addr1=8'h34, addr0=8'h56 with wr_last on the last write; pulse vsync low (VSYNC_ACT=0) -> pending=1 after the last write; outputs HH=1/2, MM=3/4, SS=5/6 exactly 1 clk after the vsync falling edge; pending=0 next.
- Write addr3=8'h25 with wr_last; hold vsync deasserted for 1000 cycles -> digit1_DAY/digit0_DAY stay 0/0 and wr_ready=0 the whole time; after the vsync edge they read 2/5 and wr_ready=1.
- Assert wr_last in the same cycle as the vsync falling edge -> no output change that frame; commit on the next vsync edge.
- With RTC_BCD_CHECK_EN defined: write addr0=8'h5A, then addr9=8'h71 with wr_last, then vsync -> SS outputs unchanged; err=1; dia_semana unchanged; pending cleared by the commit.
- Write addr9=8'h31 and addr5=8'h16 with wr_last; apply reset=0 for 1 cycle before vsync -> all outputs 0, pending=0, err=0; the following vsync edge produces no update.
- Keep vsync asserted for 3 frames' worth of cycles after one commit, with a new set written meanwhile -> exactly one commit, at the next assertion edge only.

Source files
------------

// File: rtl/rtc_digit_buffer.sv
// Frame-synchronised digit register bank for the clock screen.
// BCD bytes from the RTC controller are collected in shadow registers.
// A complete set is copied to the display registers at the start of vsync.
// Optional macro RTC_BCD_CHECK_EN rejects non-BCD data and drives a sticky err flag.
// Address map: 0 SS, 1 MM, 2 HH, 3 DAY, 4 MES, 5 YEAR, 6 SS_T, 7 MM_T, 8 HH_T, 9 CTRL.
module rtc_digit_buffer #(
  parameter logic        VSYNC_ACT = 1'b0,
  parameter int unsigned NUM_REGS  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  input  logic       vsync,
  output logic [3:0] digit0_HH,
  output logic [3:0] digit1_HH,
  output logic [3:0] digit0_MM,
  output logic [3:0] digit1_MM,
  output logic [3:0] digit0_SS,
  output logic [3:0] digit1_SS,
  output logic [3:0] digit0_DAY,
  output logic [3:0] digit1_DAY,
  output logic [3:0] digit0_MES,
  output logic [3:0] digit1_MES,
  output logic [3:0] digit0_YEAR,
  output logic [3:0] digit1_YEAR,
  output logic [3:0] digit0_HH_T,
  output logic [3:0] digit1_HH_T,
  output logic [3:0] digit0_MM_T,
  output logic [3:0] digit1_MM_T,
  output logic [3:0] digit0_SS_T,
  output logic [3:0] digit1_SS_T,
  output logic       AM_PM,
  output logic [2:0] dia_semana,
  output logic       pending,
  output logic       err
);

  localparam int unsigned NumData = 9;
  localparam logic [3:0]  CtrlAddr = 4'd9;

  // Data bytes 0-8; CTRL keeps only its meaningful fields
  logic [7:0] sh_data [NumData];
  logic       sh_am;
  logic [2:0] sh_dow;
  logic [7:0] dp_data [NumData];
  logic       dp_am;
  logic [2:0] dp_dow;

  logic vs_prev;
  logic pend;
  logic ready_en;
  logic accept;
  logic addr_ok;
  logic bad;
  logic vs_start;
  logic commit;

  // Handshake and frame-start detection
  assign wr_ready = ready_en & ~pend;
  assign accept   = wr_en & wr_ready;
  assign addr_ok  = (32'(wr_addr) < NUM_REGS) && (wr_addr <= CtrlAddr);
  assign vs_start = (vsync == VSYNC_ACT) && (vs_prev != VSYNC_ACT);
  assign commit   = vs_start & pend;

`ifdef RTC_BCD_CHECK_EN
  logic err_q;

  // Classify the incoming byte as BCD-legal for its destination
  always_comb begin
    bad = 1'b0;
    if (wr_addr == CtrlAddr) begin
      bad = (wr_data[6:4] == 3'd7) || (wr_data[3:1] != 3'd0) || wr_data[7];
    end else begin
      bad = (wr_data[7:4] > 4'd9) || (wr_data[3:0] > 4'd9);
    end
  end

  // Sticky error: only reset clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (accept && addr_ok && bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign bad = 1'b0;
  assign err = 1'b0;
`endif

  // Shadow registers collect the set being written
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NumData; i++) begin
        sh_data[i] <= 8'h00;
      end
      sh_am  <= 1'b0;
      sh_dow <= 3'd0;
    end else if (accept && addr_ok && !bad) begin
      if (wr_addr == CtrlAddr) begin
        sh_am  <= wr_data[0];
        sh_dow <= wr_data[6:4];
      end else begin
        sh_data[wr_addr] <= wr_data;
      end
    end
  end

  // Set tracking; accept needs !pend and commit needs pend, so they never collide
  always_ff @(posedge clk) begin
    if (!reset) begin
      vs_prev  <= ~VSYNC_ACT;
      pend     <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      vs_prev  <= vsync;
      ready_en <= 1'b1;
      if (accept && wr_last) begin
        pend <= 1'b1;
      end else if (commit) begin
        pend <= 1'b0;
      end
    end
  end

  // Display registers load the whole set at once on a frame start
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NumData; i++) begin
        dp_data[i] <= 8'h00;
      end
      dp_am  <= 1'b0;
      dp_dow <= 3'd0;
    end else if (commit) begin
      for (int i = 0; i < NumData; i++) begin
        dp_data[i] <= sh_data[i];
      end
      dp_am  <= sh_am;
      dp_dow <= sh_dow;
    end
  end

  assign pending = pend;

  assign {digit1_SS, digit0_SS}     = dp_data[0];
  assign {digit1_MM, digit0_MM}     = dp_data[1];
  assign {digit1_HH, digit0_HH}     = dp_data[2];
  assign {digit1_DAY, digit0_DAY}   = dp_data[3];
  assign {digit1_MES, digit0_MES}   = dp_data[4];
  assign {digit1_YEAR, digit0_YEAR} = dp_data[5];
  assign {digit1_SS_T, digit0_SS_T} = dp_data[6];
  assign {digit1_MM_T, digit0_MM_T} = dp_data[7];
  assign {digit1_HH_T, digit0_HH_T} = dp_data[8];
  assign AM_PM                      = dp_am;
  assign dia_semana                 = dp_dow;

endmodule
